// File: rtl/dbus_arbiter.sv
// Two-master (CPU/DMA) round-robin arbiter for a byte-wide device bus.
// Latency: request sampled in IDLE -> done pulse three edges later (MIN_WAIT=0, ack high).
// Backpressure: bus_ack_i stretches ACCESS; losing requester waits with req held.
// Optional feature: define DBUS_TIMEOUT_EN to abort ACCESS after 16 unacked cycles.
module dbus_arbiter #(
  parameter int MIN_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic        cpu_io_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  output logic        cpu_done_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [15:0] dma_addr_i,
  input  logic [7:0]  dma_wdata_i,
  output logic [7:0]  dma_rdata_o,
  output logic        dma_done_o,
  output logic [5:0]  bus_adr_o,
  output logic [7:0]  bus_dout_o,
  input  logic [7:0]  bus_din_i,
  input  logic        bus_ack_i,
  output logic        ram_re_o,
  output logic        ram_we_o,
  output logic        io_re_o,
  output logic        io_we_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [2:0] MW = 3'(MIN_WAIT);

  logic [1:0] state_q, state_d;
  logic       gnt_dma_q;
  logic       last_dma_q;
  logic       we_q;
  logic       io_q;
  logic [2:0] wait_q;
  logic       ram_re_q, ram_we_q, io_re_q, io_we_q;
  logic       cpu_done_q, dma_done_q;
  logic [7:0] cpu_rdata_q, dma_rdata_q;
  logic [5:0] bus_adr_q;
  logic [7:0] bus_dout_q;

  logic       any_req;
  logic       pick_dma;
  logic       cpu_io_dec, dma_io_dec;
  logic       sel_we, sel_io;
  logic [5:0] sel_adr;
  logic [7:0] sel_wdata;
  logic       at_min;
  logic       ack_ok;
  logic       to_hit;
  logic       access_end;
  logic [7:0] rd_val;

  // Arbitration and address decode of the candidate request seen in IDLE
  always_comb begin
    any_req    = cpu_req_i | dma_req_i;
    pick_dma   = (cpu_req_i & dma_req_i) ? ~last_dma_q : dma_req_i;
    cpu_io_dec = cpu_io_i |
                 ((cpu_addr_i[15:7] == 9'd0) & (cpu_addr_i[6] ^ cpu_addr_i[5]));
    dma_io_dec = (dma_addr_i[15:7] == 9'd0) & (dma_addr_i[6] ^ dma_addr_i[5]);
    sel_we     = pick_dma ? dma_we_i    : cpu_we_i;
    sel_io     = pick_dma ? dma_io_dec  : cpu_io_dec;
    sel_wdata  = pick_dma ? dma_wdata_i : cpu_wdata_i;
    if (pick_dma) begin
      sel_adr = {dma_addr_i[6], dma_addr_i[4:0]};
    end else if (cpu_io_i) begin
      sel_adr = cpu_addr_i[5:0];
    end else begin
      sel_adr = {cpu_addr_i[6], cpu_addr_i[4:0]};
    end
  end

  // The wait counter saturates at MIN_WAIT, so equality means "minimum reached"
  assign at_min = (wait_q == MW);
  assign ack_ok = at_min & bus_ack_i;

`ifdef DBUS_TIMEOUT_EN
  logic [3:0] to_q;
  logic       to_flag_q;
  logic       err_q;

  assign to_hit = (state_q == ACCESS) & at_min & ~bus_ack_i & (to_q == 4'hF);

  // Timeout counter: counts unacked cycles once the minimum wait has elapsed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q      <= 4'd0;
      to_flag_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state_q == DONE) & to_flag_q;
      if (state_q == SETUP) begin
        to_q      <= 4'd0;
        to_flag_q <= 1'b0;
      end else if (state_q == ACCESS && at_min && !bus_ack_i) begin
        to_q <= to_q + 4'd1;
        if (to_hit) to_flag_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign to_hit = 1'b0;
  assign err_o  = 1'b0;
`endif

  assign access_end = ack_ok | to_hit;
  assign rd_val     = to_hit ? 8'hFF : bus_din_i;

  // Next-state selection for the four-phase bus cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (access_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched request fields, strobes, read data and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_dma_q   <= 1'b0;
      last_dma_q  <= 1'b1;
      we_q        <= 1'b0;
      io_q        <= 1'b0;
      wait_q      <= 3'd0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      io_re_q     <= 1'b0;
      io_we_q     <= 1'b0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      cpu_rdata_q <= 8'd0;
      dma_rdata_q <= 8'd0;
      bus_adr_q   <= 6'd0;
      bus_dout_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_dma_q  <= pick_dma;
            last_dma_q <= pick_dma;
            we_q       <= sel_we;
            io_q       <= sel_io;
            bus_adr_q  <= sel_adr;
            if (sel_we) bus_dout_q <= sel_wdata;
          end
        end
        SETUP: begin
          wait_q   <= 3'd0;
          ram_re_q <= ~io_q & ~we_q;
          ram_we_q <= ~io_q &  we_q;
          io_re_q  <=  io_q & ~we_q;
          io_we_q  <=  io_q &  we_q;
        end
        ACCESS: begin
          if (access_end) begin
            ram_re_q <= 1'b0;
            ram_we_q <= 1'b0;
            io_re_q  <= 1'b0;
            io_we_q  <= 1'b0;
            if (!we_q) begin
              if (gnt_dma_q) dma_rdata_q <= rd_val;
              else           cpu_rdata_q <= rd_val;
            end
          end else if (!at_min) begin
            wait_q <= wait_q + 3'd1;
          end
        end
        DONE: begin
          cpu_done_q <= ~gnt_dma_q;
          dma_done_q <=  gnt_dma_q;
        end
        default: ;
      endcase
    end
  end

  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;
  assign cpu_done_o  = cpu_done_q;
  assign dma_done_o  = dma_done_q;
  assign bus_adr_o   = bus_adr_q;
  assign bus_dout_o  = bus_dout_q;
  assign ram_re_o    = ram_re_q;
  assign ram_we_o    = ram_we_q;
  assign io_re_o     = io_re_q;
  assign io_we_o     = io_we_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 Parameter: MIN_WAIT, default 0, minimum ACCESS cycles (0-7) before bus_ack is honoured.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req / dma_req  input  1  access request; held high until matching done pulse.
REQ-005 cpu_we / dma_we  input  1  1 = write, 0 = read.
REQ-006 cpu_io  input  1  explicit I/O access (CPU only).
REQ-007 cpu_addr / dma_addr  input  16  byte address.
REQ-008 cpu_wdata / dma_wdata  input  8  write data.
REQ-009 cpu_rdata / dma_rdata  output  8  registered read data.
REQ-010 cpu_done / dma_done  output  1  one-cycle completion pulse.
REQ-011 bus_adr  output  6  device address.
REQ-012 bus_dout  output  8  write data to bus.
REQ-013 bus_din  input  8  read data from bus.
REQ-014 bus_ack  input  1  device ready.
REQ-015 ram_re, ram_we, io_re, io_we  output  1  bus strobes, registered.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 err  output  1  timeout pulse (DBUS_TIMEOUT_EN only; else tied 0).

Function
REQ-018 FSM states SHALL be IDLE, SETUP, ACCESS, DONE.
REQ-019 IDLE: any req -> latch grant, we, addr, wdata, io-decode; go SETUP; no req -> stay.
REQ-020 Arbitration SHALL be round-robin: both requesting -> grant the one not granted last; single requester -> granted.
REQ-021 I/O decode SHALL be io = cpu_io | (addr[15:7]==0 & (addr[6]^addr[5])); DMA uses the address term only.
REQ-022 bus_adr SHALL be addr[5:0] when cpu_io set, else {addr[6], addr[4:0]}.
REQ-023 SETUP: one cycle; bus_adr and bus_dout (writes) driven; all strobes low.
REQ-024 ACCESS: exactly one strobe high, selected by io and we; wait counter counts from 0.
REQ-025 ACCESS exit: counter >= MIN_WAIT and bus_ack=1 -> read captures bus_din into granted rdata; go DONE.
REQ-026 bus_ack before MIN_WAIT reached SHALL be ignored.
REQ-027 DONE: strobes low; granted done pulses one cycle; other done stays low; go IDLE.
REQ-028 Minimum latency, MIN_WAIT=0, ack tied high: req sampled in IDLE at edge N -> done high after edge N+3.
REQ-029 Latched fields SHALL NOT change SETUP through DONE; req drop or input change mid-access ignored.
REQ-030 Request arriving while busy waits; serviced at next IDLE per REQ-020.
REQ-031 Requester sees done and drops req before next edge; req still high in IDLE starts a new access.
REQ-032 Non-granted rdata SHALL hold its value; writes leave both rdata unchanged.
REQ-033 bus_adr, bus_dout SHALL hold last values in IDLE.

Reset
REQ-034 rst_n low SHALL immediately force: state IDLE, all strobes 0, done 0, err 0, busy 0, rdata 0, bus_adr 0, bus_dout 0, wait counter 0, last-grant = DMA (CPU wins first tie).
REQ-035 Reset mid-access SHALL abort without completion pulse; first post-reset access starts from IDLE.

Configuration
REQ-036 Macro DBUS_TIMEOUT_EN defined: ACCESS with no accepted ack for 16 cycles after MIN_WAIT reached -> go DONE, granted rdata = 0xFF (reads), err pulses with done.
REQ-037 Macro DBUS_TIMEOUT_EN undefined: ACCESS waits indefinitely for ack; err tied 0; no timeout counter.

Verification
REQ-038 Reset, cpu_req read addr 0x0085, MIN_WAIT=0, ack=1, bus_din=0x5A -> SETUP with bus_adr=0x05, ram_re one cycle, cpu_rdata=0x5A, cpu_done at cycle 3.
REQ-039 cpu_req write addr 0x0043 data 0x9C -> io_we high in ACCESS, bus_adr=0x23, bus_dout=0x9C, ram_we never high.
REQ-040 cpu_req and dma_req together, held -> CPU, DMA, CPU grants in order; one done per access.
REQ-041 MIN_WAIT=3, ack high from start of ACCESS -> strobe high exactly 4 cycles, then done.
REQ-042 rst_n low during ACCESS -> strobes drop same cycle, no done; post-reset request completes normally.
REQ-043 DBUS_TIMEOUT_EN defined, ack=0, DMA read -> after 16 cycles dma_done and err pulse, dma_rdata=0xFF.
